// File: rtl/text_write_sequencer.sv
// Text-mode character writer: turns character/clear requests into
// framebuffer line writes and colour-cell writes during display blanking.
`timescale 1ns/1ps
module text_write_sequencer #(
   parameter int COLS    = 80,
   parameter int ROWS    = 30,
   parameter int GLYPH_H = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_req,
   input  logic [7:0]  wr_char,
   input  logic [2:0]  wr_color,
   input  logic        clr_req,
   input  logic        blank,
   output logic [11:0] glyph_addr,
   input  logic [7:0]  glyph_data,
   output logic        fb_we,
   output logic [15:0] fb_addr,
   output logic [7:0]  fb_wdata,
   output logic        col_we,
   output logic [11:0] col_addr,
   output logic [2:0]  col_wdata,
   output logic [6:0]  cur_x,
   output logic [4:0]  cur_y,
   output logic        busy
);

   localparam int LOG2H = $clog2(GLYPH_H);

   typedef enum logic [2:0] {IDLE, FETCH, WRITE, ADVANCE, CLEAR} state_t;

   state_t      r_state, w_next;
   logic [6:0]  r_cur_x;
   logic [4:0]  r_cur_y;
   logic [3:0]  r_row;
   logic [7:0]  r_char;
   logic [2:0]  r_color;
   logic        r_cr;
   logic [8:0]  r_clr_line;
   logic [6:0]  r_clr_col;

   logic [8:0]  w_line;
   logic        w_x_last, w_y_last, w_row_last;
   logic        w_clr_col_last, w_clr_line_last, w_clr_cell_row;
   logic [4:0]  w_clr_row_idx;

   assign w_line          = (9'(r_cur_y) << LOG2H) | 9'(r_row);
   assign w_x_last        = (r_cur_x == 7'(COLS - 1));
   assign w_y_last        = (r_cur_y == 5'(ROWS - 1));
   assign w_row_last      = (r_row == 4'(GLYPH_H - 1));
   assign w_clr_col_last  = (r_clr_col == 7'(COLS - 1));
   assign w_clr_line_last = (r_clr_line == 9'(ROWS * GLYPH_H - 1));
   assign w_clr_cell_row  = ((r_clr_line & 9'(GLYPH_H - 1)) == '0);
   assign w_clr_row_idx   = 5'(r_clr_line >> LOG2H);

   // glyph address held from FETCH through WRITE (row changes only after a write)
   assign glyph_addr = {r_char, r_row};
   assign busy       = (r_state != IDLE);
   assign cur_x      = r_cur_x;
   assign cur_y      = r_cur_y;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next-state and write strobes; strobes qualified by blank so nothing lands during active video
   always_comb begin
      w_next    = r_state;
      fb_we     = 1'b0;
      fb_addr   = '0;
      fb_wdata  = '0;
      col_we    = 1'b0;
      col_addr  = '0;
      col_wdata = '0;
      case (r_state)
         IDLE: begin
            if (clr_req)     w_next = CLEAR;
            else if (wr_req) w_next = (wr_char == 8'h0D) ? ADVANCE : FETCH;
         end
         FETCH: w_next = WRITE;
         WRITE: begin
            fb_addr   = {w_line, r_cur_x};
            fb_wdata  = glyph_data;
            col_addr  = {r_cur_y, r_cur_x};
            col_wdata = r_color;
            if (blank) begin
               fb_we  = 1'b1;
               col_we = (r_row == '0);
               w_next = w_row_last ? ADVANCE : FETCH;
            end
         end
         ADVANCE: w_next = IDLE;
         CLEAR: begin
            fb_addr   = {r_clr_line, r_clr_col};
            col_addr  = {w_clr_row_idx, r_clr_col};
            col_wdata = 3'b111;
            if (blank) begin
               fb_we  = 1'b1;
               col_we = w_clr_cell_row;
               if (w_clr_col_last && w_clr_line_last) w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // cursor, glyph row counter, latched request and clear sweep counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_x    <= '0;
         r_cur_y    <= '0;
         r_row      <= '0;
         r_char     <= '0;
         r_color    <= '0;
         r_cr       <= 1'b0;
         r_clr_line <= '0;
         r_clr_col  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_row <= '0;
               if (clr_req) begin
                  r_clr_line <= '0;
                  r_clr_col  <= '0;
               end else if (wr_req) begin
                  r_char  <= wr_char;
                  r_color <= wr_color;
                  r_cr    <= (wr_char == 8'h0D);
               end
            end
            WRITE: begin
               if (blank && !w_row_last) r_row <= r_row + 4'd1;
            end
            ADVANCE: begin
               if (r_cr || w_x_last) begin
                  r_cur_x <= '0;
                  r_cur_y <= w_y_last ? '0 : r_cur_y + 5'd1;
               end else begin
                  r_cur_x <= r_cur_x + 7'd1;
               end
            end
            CLEAR: begin
               if (blank) begin
                  if (w_clr_col_last) begin
                     r_clr_col <= '0;
                     if (w_clr_line_last) begin
                        r_cur_x <= '0;
                        r_cur_y <= '0;
                     end else begin
                        r_clr_line <= r_clr_line + 9'd1;
                     end
                  end else begin
                     r_clr_col <= r_clr_col + 7'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_text_write_sequencer.sv
// Scoreboard bench for text_write_sequencer: stimulus pushes expected
// framebuffer/colour writes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_text_write_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_req, clr_req, blank;
   logic [7:0]  wr_char;
   logic [2:0]  wr_color;
   logic [11:0] glyph_addr;
   logic [7:0]  glyph_data;
   logic        fb_we, col_we, busy;
   logic [15:0] fb_addr;
   logic [7:0]  fb_wdata;
   logic [11:0] col_addr;
   logic [2:0]  col_wdata;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;

   text_write_sequencer #(.COLS(80), .ROWS(30), .GLYPH_H(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_char(wr_char),
      .wr_color(wr_color), .clr_req(clr_req), .blank(blank),
      .glyph_addr(glyph_addr), .glyph_data(glyph_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
      .col_we(col_we), .col_addr(col_addr), .col_wdata(col_wdata),
      .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
   );

   always #5 clk = ~clk;

   // glyph ROM model, 1-cycle latency: row bits = char ^ {row,row}
   always @(posedge clk) glyph_data <= glyph_addr[11:4] ^ {glyph_addr[3:0], glyph_addr[3:0]};

   int n_chk = 0;
   int n_fail = 0;
   logic [23:0] fb_q[$];
   logic [14:0] col_q[$];
   int mx = 0, my = 0;
   int blank_mode = 0;
   int bcnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // blank generator: constant high, or high one cycle in four
   initial begin
      blank = 1'b1;
      forever begin
         @(posedge clk); #1;
         bcnt++;
         blank = (blank_mode == 0) ? 1'b1 : ((bcnt % 4) == 0);
      end
   end

   // monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (fb_we) begin
            check("fb_we_qualified", {30'd0, blank, busy}, 3);
            if (fb_q.size() == 0) check("fb_unexpected", {8'd0, fb_addr, fb_wdata}, -1);
            else check("fb_write", {8'd0, fb_addr, fb_wdata}, {8'd0, fb_q.pop_front()});
         end
         if (col_we) begin
            check("col_we_qualified", {30'd0, blank, busy}, 3);
            if (col_q.size() == 0) check("col_unexpected", {17'd0, col_addr, col_wdata}, -1);
            else check("col_write", {17'd0, col_addr, col_wdata}, {17'd0, col_q.pop_front()});
         end
      end
   end

   task automatic model_advance(input bit cr);
      if (cr || mx == 79) begin
         mx = 0;
         my = (my == 29) ? 0 : my + 1;
      end else begin
         mx++;
      end
   endtask

   task automatic push_char(input logic [7:0] c, input logic [2:0] colr);
      int line;
      logic [3:0] r4;
      if (c == 8'h0D) begin
         model_advance(1'b1);
      end else begin
         for (int r = 0; r < 16; r++) begin
            line = my * 16 + r;
            r4 = 4'(r);
            fb_q.push_back({line[8:0], mx[6:0], c ^ {r4, r4}});
         end
         col_q.push_back({my[4:0], mx[6:0], colr});
         model_advance(1'b0);
      end
   endtask

   task automatic issue(input logic [7:0] c, input logic [2:0] colr, input bit clr);
      wr_char = c; wr_color = colr; wr_req = 1'b1; clr_req = clr;
      @(posedge clk); #1;
      wr_req = 1'b0; clr_req = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output int cyc);
      cyc = 1;
      while (busy && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (busy) check("busy_timeout", 1, 0);
   endtask

   task automatic write_char(input logic [7:0] c, input logic [2:0] colr);
      int cyc;
      push_char(c, colr);
      issue(c, colr, 1'b0);
      wait_idle(2000, cyc);
   endtask

   task automatic check_cursor(input string name);
      check(name, {cur_y, cur_x}, {my[4:0], mx[6:0]});
   endtask

   task automatic check_drained(input string name);
      check({name, "_fbq"}, fb_q.size(), 0);
      check({name, "_colq"}, col_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n = 1'b0; wr_req = 1'b0; clr_req = 1'b0; wr_char = '0; wr_color = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_strobes", {fb_we, col_we, busy}, 0);
      check("reset_addr", {fb_addr, col_addr}, 0);
      check("reset_data", {glyph_addr, fb_wdata, col_wdata}, 0);
      check("reset_cursor", {cur_y, cur_x}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 'A' in red at (0,0), blank held high, busy timing
      push_char(8'h41, 3'b100);
      issue(8'h41, 3'b100, 1'b0);
      check("busy_after_accept", busy, 1);
      wait_idle(100, cyc);
      check("busy_fall_cycle", cyc, 34);
      check_cursor("cursor_after_A");
      check_drained("A");

      // blank high one cycle in four
      blank_mode = 1;
      write_char(8'h42, 3'b010);
      check_cursor("cursor_after_B_gated");
      check_drained("B");
      blank_mode = 0;

      // carriage returns down to row 29, then CR from (5,29) wraps to (0,0)
      for (int i = 0; i < 29; i++) write_char(8'h0D, 3'b000);
      check_cursor("cursor_row29");
      for (int i = 0; i < 5; i++) write_char(8'h61 + 8'(i), 3'b001);
      check_cursor("cursor_5_29");
      write_char(8'h0D, 3'b111);
      check_cursor("cursor_cr_wrap");
      check_drained("cr_wrap");

      // fill to (79,29), then write the last cell and wrap to (0,0)
      for (int i = 0; i < 29; i++) write_char(8'h0D, 3'b000);
      for (int i = 0; i < 79; i++) write_char(8'h20 + 8'(i), 3'(i));
      check_cursor("cursor_79_29");
      write_char(8'h5A, 3'b011);
      check_cursor("cursor_last_wrap");
      check_drained("last_cell");

      // requests while busy are dropped
      push_char(8'h58, 3'b110);
      issue(8'h58, 3'b110, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      wr_char = 8'h59; wr_req = 1'b1; clr_req = 1'b1;
      @(posedge clk); #1;
      wr_req = 1'b0; clr_req = 1'b0;
      wait_idle(200, cyc);
      check_cursor("cursor_dropped_req");
      check_drained("dropped_req");

      // reset in the middle of glyph row 7
      push_char(8'h52, 3'b011);
      issue(8'h52, 3'b011, 1'b0);
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_strobes", {fb_we, col_we, busy}, 0);
      check("midrst_addr", {fb_addr, col_addr, glyph_addr}, 0);
      check("midrst_cursor", {cur_y, cur_x}, 0);
      check("midrst_rows_written", fb_q.size(), 9);
      check("midrst_col_written", col_q.size(), 0);
      fb_q.delete();
      col_q.delete();
      mx = 0; my = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      write_char(8'h53, 3'b101);
      check_cursor("cursor_after_reset_write");
      check_drained("after_reset");

      // clear and write in the same cycle: clear wins
      for (int line = 0; line < 480; line++)
         for (int col = 0; col < 80; col++) begin
            fb_q.push_back({line[8:0], col[6:0], 8'h00});
            if (line % 16 == 0) col_q.push_back({5'(line / 16), col[6:0], 3'b111});
         end
      issue(8'h41, 3'b001, 1'b1);
      check("busy_clear", busy, 1);
      wait_idle(40000, cyc);
      mx = 0; my = 0;
      check_cursor("cursor_after_clear");
      check_drained("clear");
      repeat (3) @(posedge clk);
      check_drained("clear_tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/text_write_sequencer.md
TEXT_WRITE_SEQUENCER -- requirements
Module: text_write_sequencer

Interface
REQ-001: Parameter COLS, default 80, number of character columns.
REQ-002: Parameter ROWS, default 30, number of character rows.
REQ-003: Parameter GLYPH_H, default 16, pixel lines per glyph; fixed power of two.
REQ-004: clk  in  1  single system (pixel) clock; all logic on rising edge.
REQ-005: rst_n  in  1  reset, asynchronous and active-low.
REQ-006: wr_req  in  1  one-cycle pulse: write wr_char at cursor.
REQ-007: wr_char  in  8  character code (ASCII).
REQ-008: wr_color  in  3  {red,green,blue} foreground for the cell.
REQ-009: clr_req  in  1  one-cycle pulse: clear whole screen, home cursor.
REQ-010: blank  in  1  high when display scan is outside the 640x480 active area; framebuffer writes permitted only then.
REQ-011: glyph_addr  out  12  {char[7:0], row[3:0]} to glyph ROM (1-cycle read latency).
REQ-012: glyph_data  in  8  glyph row bits from ROM, bit 7 = leftmost pixel.
REQ-013: fb_we  out  1  framebuffer line write strobe.
REQ-014: fb_addr  out  16  {line[8:0], col[6:0]}, line = cur_y*GLYPH_H + row.
REQ-015: fb_wdata  out  8  glyph row bits written.
REQ-016: col_we  out  1  color buffer write strobe.
REQ-017: col_addr  out  12  {cur_y[4:0], cur_x[6:0]}.
REQ-018: col_wdata  out  3  color written.
REQ-019: cur_x  out  7 / cur_y  out  5  current cursor cell.
REQ-020: busy  out  1  high from cycle after request acceptance until operation done.

Function
REQ-021: FSM states IDLE, FETCH, WRITE, ADVANCE, CLEAR.
REQ-022: Requests accepted only in IDLE; wr_req/clr_req while busy are dropped, no queueing.
REQ-023: clr_req and wr_req in same cycle: clear executes, write dropped.
REQ-024: Accepted wr_req latches wr_char, wr_color; row=0; busy=1 next cycle.
REQ-025: wr_char 0x0D: no memory writes; go to ADVANCE, cursor to col 0 of next row (row ROWS-1 wraps to 0).
REQ-026: FETCH: drive glyph_addr={char,row} for one cycle, go to WRITE; glyph_addr held stable through WRITE.
REQ-027: WRITE: if blank=0, stall (no strobes); if blank=1, pulse fb_we one cycle with fb_addr per REQ-014, fb_wdata=glyph_data.
REQ-028: Row 0 write also pulses col_we same cycle with col_addr=cursor, col_wdata=latched color.
REQ-029: After write: row<GLYPH_H-1 -> row+1, FETCH; row=GLYPH_H-1 -> ADVANCE.
REQ-030: ADVANCE (one cycle): cur_x+1; cur_x=COLS-1 -> cur_x=0, cur_y+1; cur_y=ROWS-1 with cur_x=COLS-1 -> (0,0); busy=0 next cycle, IDLE.
REQ-031: With blank held 1, write completes in exactly 2*GLYPH_H+1 cycles after acceptance (33 at defaults); busy falls at cycle 34.
REQ-032: CLEAR: sweep fb_addr line 0..ROWS*GLYPH_H-1, col 0..COLS-1 (col fastest), fb_wdata=0, one write per blank=1 cycle, stall when blank=0.
REQ-033: In CLEAR, when line%GLYPH_H==0 also pulse col_we, col_addr={line/GLYPH_H, col}, col_wdata=3'b111.
REQ-034: CLEAR completes after ROWS*GLYPH_H*COLS writes (38400); cursor set (0,0); IDLE; busy=0.
REQ-035: fb_we and col_we never asserted when blank=0; never asserted in IDLE.
REQ-036: Addresses computed exactly; no writes beyond col COLS-1 or line ROWS*GLYPH_H-1.

Reset
REQ-037: rst_n low asynchronously forces IDLE, cur_x=0, cur_y=0, busy=0, fb_we=0, col_we=0, all address/data outputs 0.
REQ-038: Reset mid-operation abandons it; partially written cell left as is; first accepted request after release starts clean.

Verification
REQ-039: blank=1, wr_req with 0x41, color 3'b100 at (0,0) -> 16 fb_we at lines 0..15 col 0, one col_we addr 0 data 3'b100, cursor (1,0), busy low 34 cycles after request.
REQ-040: blank toggling 1 cycle high per 4 -> no strobe while blank=0, same 16 writes, cursor advances once.
REQ-041: Cursor at (79,29), wr_req -> writes to lines 464..479 col 79, cursor (0,0); at (5,29) wr_char 0x0D -> zero writes, cursor (0,0).
REQ-042: clr_req with wr_req same cycle, blank=1 -> 38400 fb_we data 0, 2400 col_we data 3'b111, cursor (0,0), no glyph write.
REQ-043: wr_req during busy -> ignored, exactly one character written.
REQ-044: rst_n low at row 7 of a write -> outputs zero immediately; after release, next wr_req completes normally at (0,0).
